pipeline_flow_ctrl: RTL and testbench
=====================================

# pipeline_flow_ctrl

Central hazard and sequencing controller for the 5-stage pipeline (IF, ID, EX, ME, WB). Each cycle it issues one `cond` code per stage (FLOW / STALL / ZERO) and the ID-stage forwarding selects, based on:

- the register read/write addresses the stages report;
- load indications;
- the multi-cycle multiply/divide handshake;
- ALU overflow;
- an external halt.

It owns the only sequential hazard state in the core: the mult/div wait FSM and its watchdog counter.

## Interface
Parameters:
- `MD_TIMEOUT`, default 40: maximum cycles spent in MD_WAIT before a forced release.
- `CNT_W`, default 6: width of the watchdog counter; must satisfy 2^CNT_W > MD_TIMEOUT.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `cpu_stall`  in  1  external halt; freezes the whole pipe.
- `id_raddr1`, `id_raddr2`  in  7  ID source operands. 7'd0 = none. GPR 1..31, HI = 7'd32, LO = 7'd33, CP0 n = 7'd64+n.
- `id_uses_rt`  in  1  ID instruction stores Rt (store forwarding is needed).
- `ex_waddr`, `me_waddr`, `wb_waddr`  in  7  destination of the instruction in each stage (same encoding as above).
- `ex_dmem_r`, `me_dmem_r`  in  1  instruction in that stage is a load.
- `ex_cal_ena`  in  1  EX holds a mult/div; the calculator is busy.
- `ex_cal_finish`  in  1  calculator result valid.
- `ex_overflow`  in  1  overflow-trapping ALU op overflowed in EX.
- `if_cond`, `id_cond`, `ex_cond`, `me_cond`, `wb_cond`  out  2  stage control: FLOW = 2'b00, STALL = 2'b01, ZERO = 2'b10.
- `fwd_a_sel`, `fwd_b_sel`, `fwd_rt_sel`  out  2  forwarding source: 0 = regfile, 1 = EX result, 2 = ME result, 3 = ME load data.
- `md_busy`  out  1  FSM is in MD_WAIT.
- `md_timeout`  out  1  sticky; set on a watchdog release, cleared only by reset.

## Operation
FSM states: RUN, MD_WAIT, MD_DRAIN.
- RUN to MD_WAIT: `ex_cal_ena` high and `ex_cal_finish` low.
- MD_WAIT to MD_DRAIN: `ex_cal_finish` high, or counter reaches MD_TIMEOUT-1 (the timeout path also sets `md_timeout`).
- MD_DRAIN to RUN: unconditional, after one cycle.

Counter behaviour:
- Cleared on entry to MD_WAIT.
- Increments each MD_WAIT cycle in which `cpu_stall` is low.

Cond priority, highest first:
1. `reset` high: all cond = ZERO.
2. `cpu_stall` high: all cond = STALL. FSM and counter hold.
3. MD_WAIT, or RUN with `ex_cal_ena` and not `ex_cal_finish`: IF, ID, EX = STALL; ME = ZERO (bubble); WB = FLOW.
4. `ex_overflow`: ME = ZERO, so the faulting result is squashed. All other stages FLOW.
5. Load-use hazard: `ex_dmem_r` high and `ex_waddr` ≠ 0 and `ex_waddr` equals a nonzero `id_raddr1` or `id_raddr2`. Response: IF, ID = STALL; EX = ZERO; ME, WB = FLOW.
6. Otherwise all FLOW. MD_DRAIN behaves as FLOW.

Forwarding, evaluated per operand (A uses raddr1; B and Rt use raddr2, with Rt qualified by `id_uses_rt`):
- A match is raddr ≠ 0 and raddr = stage waddr.
- EX match and not `ex_dmem_r`: select 1.
- Else ME match: select 3 if `me_dmem_r`, otherwise 2.
- Else: select 0.
- WB needs no forwarding, because the regfile writes at posedge and ID reads after it.
- All selects are forced to 0 whenever `id_cond` ≠ FLOW.

## Timing
- cond and fwd outputs are combinational from the inputs plus registered state. There is no added latency: a hazard detected in cycle n drives cond in cycle n.
- FSM, counter and `md_timeout` update on posedge clk.
- `md_busy` is registered. It is 0 out of reset and goes high the cycle after MD_WAIT is entered.
- Reset values: state RUN, counter 0, `md_busy` 0, `md_timeout` 0. All cond = ZERO and all fwd = 0 while reset is high; all cond = FLOW in the first cycle after release, absent hazards.
- Reset asserted mid-MD_WAIT: the FSM returns to RUN immediately.
- `ex_cal_finish` in the same cycle as `ex_cal_ena` with the FSM in RUN: go straight to MD_DRAIN-equivalent FLOW, with no wait state.
- Load-use and overflow in the same cycle: overflow wins.

## Structure
- `define.vh` holds `PARTS_COND_FLOW`, `PARTS_COND_STALL`, `PARTS_COND_ZERO`, the FWD_* select codes, and the reg-address constants (HI = 32, LO = 33, CP0 base = 64).
- One sub-module, `hazard_match`: combinational address compare producing the match bits for one operand. Instantiated three times.

## Test plan
- `id_raddr1` = 5, `ex_waddr` = 5, `ex_dmem_r` = 1 → IF/ID = STALL, EX = ZERO for exactly 1 cycle. Next cycle, with the load now in ME, `fwd_a_sel` = 3.
- `ex_cal_ena` = 1, `ex_cal_finish` rises after 33 cycles → IF/ID/EX STALL and ME ZERO throughout; `md_busy` goes 0 → 1 → 0; all FLOW after MD_DRAIN.
- `ex_cal_ena` held with `ex_cal_finish` never asserted → release after 40 cycles; `md_timeout` = 1 and stays set.
- `ex_overflow` = 1 together with a load-use hazard → ME = ZERO, all other stages FLOW.
- `id_raddr2` = 7 matches both `ex_waddr` = 7 (non-load) and `me_waddr` = 7 → `fwd_b_sel` = 1. With `id_raddr2` = 0 instead → select 0.
- `cpu_stall` pulsed for 3 cycles during MD_WAIT → all STALL and the counter frozen; the cycle count resumes afterwards. Reset asserted mid-wait → all ZERO, state RUN.

Source files
------------

// File: rtl/pipeline_flow_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/sequencing controller: stage cond codes,
// forwarding selects, register-address constants and the mult/div wait FSM states.
package pipeline_flow_ctrl_pkg;

  localparam logic [1:0] COND_FLOW  = 2'b00;
  localparam logic [1:0] COND_STALL = 2'b01;
  localparam logic [1:0] COND_ZERO  = 2'b10;

  localparam logic [1:0] FWD_REG     = 2'd0;
  localparam logic [1:0] FWD_EX      = 2'd1;
  localparam logic [1:0] FWD_ME      = 2'd2;
  localparam logic [1:0] FWD_ME_LOAD = 2'd3;

  localparam logic [6:0] REG_NONE     = 7'd0;
  localparam logic [6:0] REG_HI       = 7'd32;
  localparam logic [6:0] REG_LO       = 7'd33;
  localparam logic [6:0] REG_CP0_BASE = 7'd64;

  typedef enum logic [1:0] {
    StRun,
    StMdWait,
    StMdDrain
  } md_state_e;

  // A load still in EX has no data yet; that case is covered by the load-use stall.
  function automatic logic [1:0] fwd_select(input logic ex_match, input logic me_match,
                                            input logic ex_dmem_r, input logic me_dmem_r);
    if (ex_match && !ex_dmem_r) return FWD_EX;
    if (me_match) return me_dmem_r ? FWD_ME_LOAD : FWD_ME;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/pipeline_flow_ctrl_hazard_match.sv
// Address compare for one ID source operand against the EX and ME destinations.
module pipeline_flow_ctrl_hazard_match
  import pipeline_flow_ctrl_pkg::*;
(
  input  logic [6:0] raddr,
  input  logic [6:0] ex_waddr,
  input  logic [6:0] me_waddr,
  output logic       ex_match,
  output logic       me_match
);

  logic raddr_valid;

  assign raddr_valid = (raddr != REG_NONE);
  assign ex_match    = raddr_valid && (raddr == ex_waddr);
  assign me_match    = raddr_valid && (raddr == me_waddr);

endmodule

// File: rtl/pipeline_flow_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipe: per-stage cond codes, ID forwarding
// selects, and the mult/div wait FSM with its watchdog.
module pipeline_flow_ctrl
  import pipeline_flow_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_stall,
  input  logic [6:0] id_raddr1,
  input  logic [6:0] id_raddr2,
  input  logic       id_uses_rt,
  input  logic [6:0] ex_waddr,
  input  logic [6:0] me_waddr,
  input  logic [6:0] wb_waddr,
  input  logic       ex_dmem_r,
  input  logic       me_dmem_r,
  input  logic       ex_cal_ena,
  input  logic       ex_cal_finish,
  input  logic       ex_overflow,
  output logic [1:0] if_cond,
  output logic [1:0] id_cond,
  output logic [1:0] ex_cond,
  output logic [1:0] me_cond,
  output logic [1:0] wb_cond,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic [1:0] fwd_rt_sel,
  output logic       md_busy,
  output logic       md_timeout
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_busy_q, md_busy_d;
  logic             md_timeout_q, md_timeout_d;

  logic       a_ex, a_me, b_ex, b_me, rt_ex, rt_me;
  logic [6:0] rt_raddr;
  logic       md_stall, load_use;

  // WB writes the regfile before ID reads it, so its destination never needs a compare.
  logic unused_wb_waddr;
  assign unused_wb_waddr = ^wb_waddr;

  assign rt_raddr = id_uses_rt ? id_raddr2 : REG_NONE;

  pipeline_flow_ctrl_hazard_match u_match_a (
    .raddr    (id_raddr1),
    .ex_waddr (ex_waddr),
    .me_waddr (me_waddr),
    .ex_match (a_ex),
    .me_match (a_me)
  );

  pipeline_flow_ctrl_hazard_match u_match_b (
    .raddr    (id_raddr2),
    .ex_waddr (ex_waddr),
    .me_waddr (me_waddr),
    .ex_match (b_ex),
    .me_match (b_me)
  );

  pipeline_flow_ctrl_hazard_match u_match_rt (
    .raddr    (rt_raddr),
    .ex_waddr (ex_waddr),
    .me_waddr (me_waddr),
    .ex_match (rt_ex),
    .me_match (rt_me)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StRun;
      cnt_q        <= '0;
      md_busy_q    <= 1'b0;
      md_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      md_busy_q    <= md_busy_d;
      md_timeout_q <= md_timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    md_timeout_d = md_timeout_q;
    if (!cpu_stall) begin
      case (state_q)
        StRun: begin
          if (ex_cal_ena && !ex_cal_finish) begin
            state_d = StMdWait;
            cnt_d   = '0;
          end
        end
        StMdWait: begin
          cnt_d = cnt_q + 1'b1;
          if (ex_cal_finish) begin
            state_d = StMdDrain;
          end else if (cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
            state_d      = StMdDrain;
            md_timeout_d = 1'b1;
          end
        end
        StMdDrain: state_d = StRun;
        default:   state_d = StRun;
      endcase
    end
    md_busy_d = (state_d == StMdWait);
  end

  assign md_stall = (state_q == StMdWait) ||
                    ((state_q == StRun) && ex_cal_ena && !ex_cal_finish);
  assign load_use = ex_dmem_r && (a_ex || b_ex);

  always_comb begin
    if_cond = COND_FLOW;
    id_cond = COND_FLOW;
    ex_cond = COND_FLOW;
    me_cond = COND_FLOW;
    wb_cond = COND_FLOW;
    if (reset) begin
      if_cond = COND_ZERO;
      id_cond = COND_ZERO;
      ex_cond = COND_ZERO;
      me_cond = COND_ZERO;
      wb_cond = COND_ZERO;
    end else if (cpu_stall) begin
      if_cond = COND_STALL;
      id_cond = COND_STALL;
      ex_cond = COND_STALL;
      me_cond = COND_STALL;
      wb_cond = COND_STALL;
    end else if (md_stall) begin
      if_cond = COND_STALL;
      id_cond = COND_STALL;
      ex_cond = COND_STALL;
      me_cond = COND_ZERO;
    end else if (ex_overflow) begin
      me_cond = COND_ZERO;
    end else if (load_use) begin
      if_cond = COND_STALL;
      id_cond = COND_STALL;
      ex_cond = COND_ZERO;
    end
  end

  always_comb begin
    fwd_a_sel  = FWD_REG;
    fwd_b_sel  = FWD_REG;
    fwd_rt_sel = FWD_REG;
    if (id_cond == COND_FLOW) begin
      fwd_a_sel  = fwd_select(a_ex, a_me, ex_dmem_r, me_dmem_r);
      fwd_b_sel  = fwd_select(b_ex, b_me, ex_dmem_r, me_dmem_r);
      fwd_rt_sel = fwd_select(rt_ex, rt_me, ex_dmem_r, me_dmem_r);
    end
  end

  assign md_busy    = md_busy_q;
  assign md_timeout = md_timeout_q;

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Directed bench for pipeline_flow_ctrl: hazards, forwarding and the mult/div wait FSM.
module tb_pipeline_flow_ctrl;

  localparam logic [9:0] ALL_FLOW  = 10'b00_00_00_00_00;
  localparam logic [9:0] ALL_STALL = 10'b01_01_01_01_01;
  localparam logic [9:0] ALL_ZERO  = 10'b10_10_10_10_10;
  localparam logic [9:0] MD_PAT    = 10'b01_01_01_10_00;
  localparam logic [9:0] LU_PAT    = 10'b01_01_10_00_00;
  localparam logic [9:0] OV_PAT    = 10'b00_00_00_10_00;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_stall;
  logic [6:0] id_raddr1, id_raddr2, ex_waddr, me_waddr, wb_waddr;
  logic       id_uses_rt, ex_dmem_r, me_dmem_r, ex_cal_ena, ex_cal_finish, ex_overflow;
  logic [1:0] if_cond, id_cond, ex_cond, me_cond, wb_cond;
  logic [1:0] fwd_a_sel, fwd_b_sel, fwd_rt_sel;
  logic       md_busy, md_timeout;
  logic [9:0] conds;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign conds = {if_cond, id_cond, ex_cond, me_cond, wb_cond};

  pipeline_flow_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_stall     (cpu_stall),
    .id_raddr1     (id_raddr1),
    .id_raddr2     (id_raddr2),
    .id_uses_rt    (id_uses_rt),
    .ex_waddr      (ex_waddr),
    .me_waddr      (me_waddr),
    .wb_waddr      (wb_waddr),
    .ex_dmem_r     (ex_dmem_r),
    .me_dmem_r     (me_dmem_r),
    .ex_cal_ena    (ex_cal_ena),
    .ex_cal_finish (ex_cal_finish),
    .ex_overflow   (ex_overflow),
    .if_cond       (if_cond),
    .id_cond       (id_cond),
    .ex_cond       (ex_cond),
    .me_cond       (me_cond),
    .wb_cond       (wb_cond),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .fwd_rt_sel    (fwd_rt_sel),
    .md_busy       (md_busy),
    .md_timeout    (md_timeout)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    id_raddr1  = 7'd0;
    id_raddr2  = 7'd0;
    id_uses_rt = 1'b0;
    ex_waddr   = 7'd0;
    me_waddr   = 7'd0;
    wb_waddr   = 7'd0;
    ex_dmem_r  = 1'b0;
    me_dmem_r  = 1'b0;
    ex_overflow = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpu_stall = 1'b0;
    ex_cal_ena = 1'b0;
    ex_cal_finish = 1'b0;
    clear_ops();
    id_raddr1 = 7'd5;
    ex_waddr  = 7'd5;
    #1;
    check_val("reset_cond", conds, ALL_ZERO);
    check_val("reset_fwd_a", fwd_a_sel, 2'd0);
    check_val("reset_busy", md_busy, 1'b0);
    check_val("reset_timeout", md_timeout, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    clear_ops();
    #1;
    check_val("post_reset_flow", conds, ALL_FLOW);

    // Load-use: stall one cycle, then the load sits in ME and forwards its data.
    tick();
    id_raddr1 = 7'd5; ex_waddr = 7'd5; ex_dmem_r = 1'b1;
    #1;
    check_val("load_use_cond", conds, LU_PAT);
    check_val("load_use_fwd_a", fwd_a_sel, 2'd0);
    tick();
    ex_waddr = 7'd0; ex_dmem_r = 1'b0; me_waddr = 7'd5; me_dmem_r = 1'b1;
    #1;
    check_val("after_lu_cond", conds, ALL_FLOW);
    check_val("after_lu_fwd_a", fwd_a_sel, 2'd3);

    // Overflow beats load-use.
    tick();
    clear_ops();
    id_raddr1 = 7'd5; ex_waddr = 7'd5; ex_dmem_r = 1'b1; ex_overflow = 1'b1;
    #1;
    check_val("ovf_lu_cond", conds, OV_PAT);
    check_val("ovf_lu_fwd_a", fwd_a_sel, 2'd0);

    // Forwarding priority and the zero register.
    tick();
    clear_ops();
    id_raddr2 = 7'd7; ex_waddr = 7'd7; me_waddr = 7'd7;
    id_raddr1 = 7'd9; me_waddr = 7'd7;
    #1;
    check_val("fwd_b_ex_wins", fwd_b_sel, 2'd1);
    check_val("fwd_rt_unused", fwd_rt_sel, 2'd0);
    check_val("fwd_a_none", fwd_a_sel, 2'd0);
    id_uses_rt = 1'b1;
    #1;
    check_val("fwd_rt_ex", fwd_rt_sel, 2'd1);
    id_raddr2 = 7'd0;
    #1;
    check_val("fwd_b_zero_reg", fwd_b_sel, 2'd0);
    check_val("fwd_rt_zero_reg", fwd_rt_sel, 2'd0);
    ex_waddr = 7'd0; id_raddr1 = 7'd33; me_waddr = 7'd33;
    #1;
    check_val("fwd_a_me_alu", fwd_a_sel, 2'd2);

    // Mult/div finishing after 33 cycles.
    tick();
    clear_ops();
    ex_cal_ena = 1'b1;
    #1;
    check_val("md_first_cond", conds, MD_PAT);
    check_val("md_first_busy", md_busy, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      check_val("md_wait_cond", conds, MD_PAT);
      check_val("md_wait_busy", md_busy, 1'b1);
    end
    tick();
    ex_cal_finish = 1'b1;
    #1;
    check_val("md_finish_cond", conds, MD_PAT);
    tick();
    ex_cal_ena = 1'b0; ex_cal_finish = 1'b0;
    #1;
    check_val("md_drain_cond", conds, ALL_FLOW);
    check_val("md_drain_busy", md_busy, 1'b0);
    check_val("md_no_timeout", md_timeout, 1'b0);

    // Finish together with enable in RUN: no wait state at all.
    tick();
    ex_cal_ena = 1'b1; ex_cal_finish = 1'b1;
    #1;
    check_val("md_instant_cond", conds, ALL_FLOW);
    tick();
    ex_cal_ena = 1'b0; ex_cal_finish = 1'b0;
    #1;
    check_val("md_instant_busy", md_busy, 1'b0);

    // Watchdog: 40 wait cycles, then forced release.
    ex_cal_ena = 1'b1;
    #1;
    check_val("wd_first_cond", conds, MD_PAT);
    for (int k = 1; k <= 40; k++) begin
      tick();
      check_val("wd_wait_cond", conds, MD_PAT);
      check_val("wd_not_yet", md_timeout, 1'b0);
    end
    tick();
    ex_cal_ena = 1'b0;
    #1;
    check_val("wd_release_cond", conds, ALL_FLOW);
    check_val("wd_timeout_set", md_timeout, 1'b1);
    check_val("wd_busy_clear", md_busy, 1'b0);
    tick();
    tick();
    check_val("wd_timeout_sticky", md_timeout, 1'b1);

    // cpu_stall for 3 cycles mid-wait freezes the watchdog count.
    ex_cal_ena = 1'b1;
    #1;
    check_val("st_first_cond", conds, MD_PAT);
    for (int k = 1; k <= 10; k++) tick();
    tick();
    cpu_stall = 1'b1; id_raddr1 = 7'd3; ex_waddr = 7'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val("st_all_stall", conds, ALL_STALL);
      check_val("st_fwd_forced", fwd_a_sel, 2'd0);
      check_val("st_busy", md_busy, 1'b1);
      if (k < 2) tick();
    end
    tick();
    cpu_stall = 1'b0;
    clear_ops();
    #1;
    for (int k = 14; k <= 43; k++) begin
      check_val("st_resume_cond", conds, MD_PAT);
      if (k < 43) tick();
    end
    tick();
    ex_cal_ena = 1'b0;
    #1;
    check_val("st_release_cond", conds, ALL_FLOW);

    // Reset mid-wait drops straight back to RUN.
    tick();
    ex_cal_ena = 1'b1;
    tick();
    tick();
    check_val("rst_mid_busy_before", md_busy, 1'b1);
    id_raddr1 = 7'd4; ex_waddr = 7'd4;
    #2;
    reset = 1'b1;
    #1;
    check_val("rst_mid_cond", conds, ALL_ZERO);
    check_val("rst_mid_busy", md_busy, 1'b0);
    check_val("rst_mid_timeout", md_timeout, 1'b0);
    check_val("rst_mid_fwd", fwd_a_sel, 2'd0);
    ex_cal_ena = 1'b0;
    clear_ops();
    tick();
    reset = 1'b0;
    ex_cal_ena = 1'b1; ex_cal_finish = 1'b1;
    #1;
    check_val("rst_state_run", conds, ALL_FLOW);
    tick();
    ex_cal_ena = 1'b0; ex_cal_finish = 1'b0;
    #1;
    check_val("rst_final_flow", conds, ALL_FLOW);
    check_val("rst_final_busy", md_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
